// File: rtl/move_collector.sv
// Snapshots one square's 16 incoming ray/knight move words on start and streams
// every non-empty slot, in fixed direction order, as a decoded move record.
module move_collector #(
   parameter int NUM_DIR = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  pos,
   input  logic        start,
   input  logic [10:0] U_move,
   input  logic [10:0] D_move,
   input  logic [10:0] L_move,
   input  logic [10:0] R_move,
   input  logic [10:0] UL_move,
   input  logic [10:0] UR_move,
   input  logic [10:0] DL_move,
   input  logic [10:0] DR_move,
   input  logic [7:0]  UUL_move,
   input  logic [7:0]  UUR_move,
   input  logic [7:0]  LLU_move,
   input  logic [7:0]  RRU_move,
   input  logic [7:0]  DDL_move,
   input  logic [7:0]  DDR_move,
   input  logic [7:0]  LLD_move,
   input  logic [7:0]  RRD_move,
   output logic        mv_valid,
   input  logic        mv_ready,
   output logic [5:0]  mv_from,
   output logic [5:0]  mv_to,
   output logic [4:0]  mv_flags,
   output logic [3:0]  mv_dir,
   output logic        busy,
   output logic        done,
   output logic [4:0]  count
);

   typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

   state_t               state_r;
   logic [10:0]          ray_r [8];
   // Knight snapshot keeps {word[7], word[5:0]}; bit 6 only matters for emptiness.
   logic [6:0]           kn_r [8];
   logic [5:0]           pos_r;
   logic [NUM_DIR-1:0]   mask_r;

   logic [10:0]          ray_in_s [8];
   logic [7:0]           kn_in_s [8];
   logic [NUM_DIR-1:0]   mask_in_s;
   logic                 sel_found_s;
   logic [3:0]           sel_idx_s;
   logic [5:0]           sel_from_s;
   logic [4:0]           sel_flags_s;

   // Returns {found, index} of the lowest set bit of the mask.
   function automatic logic [4:0] lowest_set(input logic [NUM_DIR-1:0] m);
      logic [4:0] res;
      res = 5'd0;
      for (int i = NUM_DIR - 1; i >= 0; i--) begin
         if (m[i]) begin
            res = {1'b1, 4'(i)};
         end
      end
      return res;
   endfunction

   assign ray_in_s[0] = U_move;   assign ray_in_s[1] = D_move;
   assign ray_in_s[2] = L_move;   assign ray_in_s[3] = R_move;
   assign ray_in_s[4] = UL_move;  assign ray_in_s[5] = UR_move;
   assign ray_in_s[6] = DL_move;  assign ray_in_s[7] = DR_move;
   assign kn_in_s[0]  = UUL_move; assign kn_in_s[1]  = UUR_move;
   assign kn_in_s[2]  = LLU_move; assign kn_in_s[3]  = RRU_move;
   assign kn_in_s[4]  = DDL_move; assign kn_in_s[5]  = DDR_move;
   assign kn_in_s[6]  = LLD_move; assign kn_in_s[7]  = RRD_move;

   // Non-empty mask of the live inputs, ray slots in the low byte.
   always_comb begin
      mask_in_s = '0;
      for (int i = 0; i < 8; i++) begin
         mask_in_s[i]     = (ray_in_s[i] != 11'h000);
         mask_in_s[i + 8] = (kn_in_s[i] != 8'h00);
      end
   end

   // Priority select and decode of the next pending slot from the snapshot.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = 4'd0;
      sel_from_s  = 6'd0;
      sel_flags_s = 5'd0;
      {sel_found_s, sel_idx_s} = lowest_set(mask_r);
      if (sel_idx_s[3] == 1'b0) begin
         sel_from_s  = ray_r[sel_idx_s[2:0]][5:0];
         sel_flags_s = ray_r[sel_idx_s[2:0]][10:6];
      end else begin
         sel_from_s  = kn_r[sel_idx_s[2:0]][5:0];
         sel_flags_s = {kn_r[sel_idx_s[2:0]][6], 4'b0000};
      end
   end

   // Control FSM with snapshot storage and registered record outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         pos_r    <= 6'd0;
         mask_r   <= '0;
         mv_valid <= 1'b0;
         mv_from  <= 6'd0;
         mv_to    <= 6'd0;
         mv_flags <= 5'd0;
         mv_dir   <= 4'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= 5'd0;
         for (int i = 0; i < 8; i++) begin
            ray_r[i] <= 11'h000;
            kn_r[i]  <= 7'h00;
         end
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  for (int i = 0; i < 8; i++) begin
                     ray_r[i] <= ray_in_s[i];
                     kn_r[i]  <= {kn_in_s[i][7], kn_in_s[i][5:0]};
                  end
                  pos_r   <= pos;
                  mask_r  <= mask_in_s;
                  count   <= 5'd0;
                  busy    <= 1'b1;
                  state_r <= SCAN;
               end
            end
            SCAN: begin
               if (!sel_found_s) begin
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  mv_from  <= sel_from_s;
                  mv_to    <= pos_r;
                  mv_flags <= sel_flags_s;
                  mv_dir   <= sel_idx_s;
                  mv_valid <= 1'b1;
                  state_r  <= EMIT;
               end
            end
            EMIT: begin
               if (mv_ready) begin
                  mask_r[mv_dir] <= 1'b0;
                  count          <= count + 5'd1;
                  mv_valid       <= 1'b0;
                  state_r        <= SCAN;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               mv_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_move_collector.sv
// Scenario bench for move_collector: a slot-order reference model predicts the
// record stream, which is compared with what the DUT hands over the stream port.
module tb_move_collector;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  pos = 6'd0;
   logic        start = 1'b0;
   logic        mv_ready = 1'b0;
   logic [10:0] ray_w [8];
   logic [7:0]  kn_w [8];
   logic        mv_valid, busy, done;
   logic [5:0]  mv_from, mv_to;
   logic [4:0]  mv_flags, count;
   logic [3:0]  mv_dir;

   int n_checks = 0;
   int n_pass = 0;

   logic [20:0] exp_q [$];
   logic [20:0] obs_q [$];
   int          acc_q [$];
   int          done_at, done_pulses, hold_err, busy_err, first_len;

   always #5 clk = ~clk;

   move_collector dut (
      .clk(clk), .rst_n(rst_n), .pos(pos), .start(start),
      .U_move(ray_w[0]), .D_move(ray_w[1]), .L_move(ray_w[2]), .R_move(ray_w[3]),
      .UL_move(ray_w[4]), .UR_move(ray_w[5]), .DL_move(ray_w[6]), .DR_move(ray_w[7]),
      .UUL_move(kn_w[0]), .UUR_move(kn_w[1]), .LLU_move(kn_w[2]), .RRU_move(kn_w[3]),
      .DDL_move(kn_w[4]), .DDR_move(kn_w[5]), .LLD_move(kn_w[6]), .RRD_move(kn_w[7]),
      .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
      .mv_flags(mv_flags), .mv_dir(mv_dir), .busy(busy), .done(done), .count(count)
   );

   task automatic clear_inputs();
      for (int d = 0; d < 8; d++) begin
         ray_w[d] = 11'h000;
         kn_w[d]  = 8'h00;
      end
   endtask

   // Each slot is non-empty with probability pct/100.
   task automatic rand_inputs(input int pct);
      for (int d = 0; d < 8; d++) begin
         ray_w[d] = ($urandom_range(99) < pct) ? 11'($urandom_range(2047, 1)) : 11'h000;
         kn_w[d]  = ($urandom_range(99) < pct) ? 8'($urandom_range(255, 1)) : 8'h00;
      end
      pos = 6'($urandom_range(63));
   endtask

   // Reference: walk directions 0..15, every non-empty word becomes one record.
   task automatic build_model();
      logic [10:0] rw;
      logic [7:0]  kw;
      exp_q.delete();
      for (int d = 0; d < 8; d++) begin
         rw = ray_w[d];
         if (rw != 11'h000) exp_q.push_back({rw[5:0], pos, rw[10:6], 4'(d)});
      end
      for (int d = 0; d < 8; d++) begin
         kw = kn_w[d];
         if (kw != 8'h00) exp_q.push_back({kw[5:0], pos, kw[7], 4'b0000, 4'(d + 8)});
      end
   endtask

   // Runs one scan started by the caller (start already high), recording what the
   // DUT delivers. mode 0: ready always 1; mode 1: random ready.
   task automatic collect(input int mode, input int low_first, input bit chaos);
      bit          rdy, holding, seen_done;
      logic [20:0] held, cur;
      int          tail;
      obs_q.delete(); acc_q.delete();
      done_at = -1; done_pulses = 0; hold_err = 0; busy_err = 0; first_len = 0;
      holding = 1'b0; seen_done = 1'b0; tail = 0; held = '0;
      for (int i = 1; i <= 400 && tail < 3; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         cur = {mv_from, mv_to, mv_flags, mv_dir};
         if (seen_done) begin
            tail++;
            start = 1'b0;
            if (busy !== 1'b0) busy_err++;
         end
         if (holding && (mv_valid !== 1'b1 || cur !== held)) hold_err++;
         if (done === 1'b1) begin
            done_pulses++;
            if (done_at < 0) done_at = i;
         end
         if (chaos && !seen_done && i >= 2) begin
            start = 1'($urandom_range(1));
            rand_inputs(60);
         end
         if (done === 1'b1 && chaos) start = 1'b1;
         if (done === 1'b1) seen_done = 1'b1;
         if (mv_valid === 1'b1) begin
            if (obs_q.size() == 0 && first_len < low_first) rdy = 1'b0;
            else if (mode == 0) rdy = 1'b1;
            else rdy = ($urandom_range(2) != 0);
            if (obs_q.size() == 0) first_len++;
         end else begin
            rdy = 1'($urandom_range(1));
         end
         mv_ready = rdy;
         if (mv_valid === 1'b1 && rdy) begin
            obs_q.push_back(cur);
            acc_q.push_back(i);
            holding = 1'b0;
         end else if (mv_valid === 1'b1) begin
            holding = 1'b1;
            held = cur;
         end else begin
            holding = 1'b0;
         end
      end
      mv_ready = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({mv_valid, mv_from, mv_to, mv_flags, mv_dir, busy, done, count} !== 30'd0)
         $display("FAIL reset_outputs got %h exp 0", {mv_valid, mv_from, mv_to, mv_flags, mv_dir, busy, done, count});
      else n_pass++;
      rst_n = 1'b1;
      // Start a scan and reset it while a record is stalled.
      pos = 6'd40; ray_w[0] = 11'h123;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; mv_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mv_valid !== 1'b1) $display("FAIL reset_pre_valid got %b exp 1", mv_valid);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({mv_valid, mv_from, mv_to, mv_flags, mv_dir, busy, done, count} !== 30'd0)
         $display("FAIL reset_mid_emit got %h exp 0", {mv_valid, mv_from, mv_to, mv_flags, mv_dir, busy, done, count});
      else n_pass++;
      @(negedge clk); rst_n = 1'b1; clear_inputs();
      @(negedge clk); start = 1'b1;
      collect(0, 0, 1'b0);
      n_checks++;
      if (done_at !== 2 || done_pulses !== 1) $display("FAIL empty_done got at=%0d pulses=%0d exp at=2 pulses=1", done_at, done_pulses);
      else n_pass++;
      n_checks++;
      if (count !== 5'd0 || obs_q.size() != 0) $display("FAIL empty_count got %0d recs=%0d exp 0", count, obs_q.size());
      else n_pass++;
   endtask

   task automatic test_single();
      clear_inputs(); pos = 6'd27; ray_w[0] = 11'b1_1000_001011;
      @(negedge clk); start = 1'b1;
      collect(0, 0, 1'b0);
      n_checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {6'd11, 6'd27, 5'b11000, 4'd0})
         $display("FAIL single_record got n=%0d rec=%h exp %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 21'h0, {6'd11, 6'd27, 5'b11000, 4'd0});
      else n_pass++;
      n_checks++;
      if (acc_q.size() != 1 || acc_q[0] != 2 || done_at != 4)
         $display("FAIL single_latency got acc=%0d done=%0d exp acc=2 done=4", (acc_q.size() > 0) ? acc_q[0] : -1, done_at);
      else n_pass++;
      n_checks++;
      if (count !== 5'd1 || done_pulses != 1) $display("FAIL single_count got %0d pulses=%0d exp 1 pulses=1", count, done_pulses);
      else n_pass++;
   endtask

   task automatic test_all_slots();
      rand_inputs(100);
      build_model();
      @(negedge clk); start = 1'b1;
      collect(0, 0, 1'b0);
      n_checks++;
      if (obs_q.size() != 16) $display("FAIL all_size got %0d exp 16", obs_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size(); k++) begin
         n_checks++;
         if (k >= obs_q.size() || obs_q[k] !== exp_q[k] || acc_q[k] != 2 + 2 * k)
            $display("FAIL all_rec%0d got %h at %0d exp %h at %0d", k, (k < obs_q.size()) ? obs_q[k] : 21'h0, (k < acc_q.size()) ? acc_q[k] : -1, exp_q[k], 2 + 2 * k);
         else n_pass++;
      end
      n_checks++;
      if (count !== 5'd16 || done_pulses != 1 || done_at != 34 || busy_err != 0)
         $display("FAIL all_done got count=%0d pulses=%0d at=%0d busyerr=%0d exp 16/1/34/0", count, done_pulses, done_at, busy_err);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      clear_inputs(); pos = 6'd9; ray_w[5] = 11'b0_0110_100001; kn_w[7] = 8'h8E;
      build_model();
      @(negedge clk); start = 1'b1;
      collect(0, 5, 1'b0);
      n_checks++;
      if (first_len != 6 || hold_err != 0) $display("FAIL bp_hold got len=%0d errs=%0d exp len=6 errs=0", first_len, hold_err);
      else n_pass++;
      n_checks++;
      if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== {6'd14, 6'd9, 5'b10000, 4'd15})
         $display("FAIL bp_records got n=%0d r1=%h exp %h", obs_q.size(), (obs_q.size() > 1) ? obs_q[1] : 21'h0, {6'd14, 6'd9, 5'b10000, 4'd15});
      else n_pass++;
      n_checks++;
      if (count !== 5'd2) $display("FAIL bp_count got %0d exp 2", count);
      else n_pass++;
   endtask

   task automatic test_busy_start();
      for (int r = 0; r < 4; r++) begin
         rand_inputs(50);
         build_model();
         @(negedge clk); start = 1'b1;
         collect(1, 0, 1'b1);
         n_checks++;
         if (obs_q.size() != exp_q.size()) $display("FAIL busy_size%0d got %0d exp %0d", r, obs_q.size(), exp_q.size());
         else n_pass++;
         for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
               $display("FAIL busy_rec%0d_%0d got %h exp %h", r, k, (k < obs_q.size()) ? obs_q[k] : 21'h0, exp_q[k]);
            else n_pass++;
         end
         n_checks++;
         if (done_pulses != 1 || busy_err != 0 || hold_err != 0 || count !== 5'(exp_q.size()))
            $display("FAIL busy_end%0d got pulses=%0d busyerr=%0d holderr=%0d count=%0d exp 1/0/0/%0d", r, done_pulses, busy_err, hold_err, count, exp_q.size());
         else n_pass++;
      end
   endtask

   task automatic test_empty_words();
      clear_inputs(); pos = 6'd50; ray_w[2] = 11'h001; kn_w[3] = 8'h00;
      @(negedge clk); start = 1'b1;
      collect(1, 0, 1'b0);
      n_checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {6'd1, 6'd50, 5'b00000, 4'd2})
         $display("FAIL lowbit_record got n=%0d rec=%h exp %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 21'h0, {6'd1, 6'd50, 5'b00000, 4'd2});
      else n_pass++;
      clear_inputs(); kn_w[1] = 8'h40;
      build_model();
      @(negedge clk); start = 1'b1;
      collect(0, 0, 1'b0);
      n_checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {6'd0, 6'd50, 5'b00000, 4'd9})
         $display("FAIL kbit6_record got n=%0d rec=%h exp %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 21'h0, {6'd0, 6'd50, 5'b00000, 4'd9});
      else n_pass++;
   endtask

   task automatic test_random();
      for (int r = 0; r < 20; r++) begin
         rand_inputs(r * 5);
         build_model();
         @(negedge clk); start = 1'b1;
         collect(1, 0, 1'b0);
         n_checks++;
         if (obs_q.size() != exp_q.size() || count !== 5'(exp_q.size()) || done_pulses != 1 || hold_err != 0)
            $display("FAIL rand%0d_summary got n=%0d count=%0d pulses=%0d holderr=%0d exp n=%0d", r, obs_q.size(), count, done_pulses, hold_err, exp_q.size());
         else n_pass++;
         for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
               $display("FAIL rand%0d_rec%0d got %h exp %h", r, k, (k < obs_q.size()) ? obs_q[k] : 21'h0, exp_q[k]);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_slots();
      test_backpressure();
      test_busy_start();
      test_empty_words();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/move_collector.md
Name: move_collector

Overview:
- Receive-side counterpart of the per-square ray transceiver.
- Sits at one board square. On a start strobe it snapshots that square's 16 registered incoming move buses (8 ray, 8 knight).
- Scans the snapshot in fixed direction order and serialises every non-empty slot as a decoded move record over a valid/ready stream to the move-list FIFO.
- Reports completion and the move count.

Parameters:
NUM_DIR, 16, number of direction slots scanned (fixed; 8 ray + 8 knight)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
pos  in  6  index of this square (0..63), used as destination square
start  in  1  one-cycle request to snapshot and scan; ignored unless idle
U_move, D_move, L_move, R_move, UL_move, UR_move, DL_move, DR_move  in  11 each  registered ray move words
UUL_move, UUR_move, LLU_move, RRU_move, DDL_move, DDR_move, LLD_move, RRD_move  in  8 each  registered knight move words
mv_valid  out  1  move record valid
mv_ready  in  1  downstream accepts record
mv_from  out  6  origin square (move word bits [5:0])
mv_to  out  6  destination square (= pos captured at start)
mv_flags  out  5  ray: word[10:6] {color, manhattan, diagonal, king, pawn}; knight: {word[7], 4'b0000}
mv_dir  out  4  slot index: U=0,D,L,R,UL,UR,DL,DR=7,UUL=8,UUR,LLU,RRU,DDL,DDR,LLD,RRD=15
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of scan
count  out  5  records accepted in current/last scan (0..16)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mv_valid=0, mv_from=0, mv_to=0, mv_flags=0, mv_dir=0, busy=0, done=0, count=0; snapshot and mask cleared. Reset mid-scan abandons the scan with no done pulse.
- Slot non-empty: ray word != 11'h000; knight word != 8'h00. Same-colour/pawn filtering is upstream and is not repeated here.
- IDLE: on the edge where start=1:
  - capture all 16 words, pos and the 16-bit non-empty mask;
  - clear count;
  - go to SCAN.
- SCAN: priority-select the lowest set mask bit.
  - None set: go to DONE.
  - Otherwise: load mv_from/mv_to/mv_flags/mv_dir from the selected slot, set mv_valid=1, go to EMIT.
- EMIT: record outputs held stable while mv_valid=1 and mv_ready=0. On the edge with mv_ready=1:
  - clear that mask bit;
  - count+1;
  - mv_valid=0;
  - go to SCAN.
  This gives one bubble cycle between consecutive records.
- DONE: done=1 for exactly one cycle, then IDLE. count holds its value until the next start.
- Latency:
  - start sampled at edge k → mv_valid high after edge k+1.
  - Handshake at edge j → next mv_valid high after edge j+1.
  - Empty snapshot: done high in the cycle after edge k+1.
- start while busy: ignored, with no effect on snapshot or state.
- Input buses changing after the snapshot have no effect on the current scan.
- mv_ready while mv_valid=0: ignored.
- Back-to-back start is accepted only in IDLE. A start asserted in the DONE cycle is ignored.
- Width rules:
  - count is 5 bits and cannot exceed 16.
  - Knight origin is word[5:0]; bit [6] is not emitted.

Test Plan:
1. Reset during EMIT (mv_valid=1, mv_ready=0) → all outputs 0 immediately on rst_n fall; after release, start with empty inputs → done after 2 cycles, count=0.
2. pos=27, only U_move=11'b1_1000_001011 (white manhattan from 11), start → after 2 cycles mv_valid=1, from=11, to=27, flags=5'b11000, dir=0. mv_ready=1 → done pulses 2 cycles later, count=1.
3. All 16 slots non-empty, mv_ready tied 1 → records emitted with dir 0..15 in order, one every 2 cycles, count=16, a single done pulse.
4. UR_move and RRD_move=8'h8E set, mv_ready low for 5 cycles on first record → dir=5 record held stable 5 cycles; then dir=15 with from=14, flags=5'b10000.
5. start pulsed during scan while inputs change → no restart; emitted records match the original snapshot only.
6. Knight word 8'h00 and ray word with only bit 0 set → ray slot emitted (from=1), knight slot skipped.
